// File: rtl/poly_result_serializer_if.sv
// Lane-word output stream of poly_result_serializer.
// master drives the words, slave returns ready.
interface poly_result_serializer_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 8
);
  localparam int LW = $clog2(NUM_LANES);

  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    out_lane;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_lane,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_lane,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/poly_result_serializer.sv
// Frame FIFO that serializes lane-result vectors onto one stream.
// POLY_RESULT_SERIALIZER_DROP_COUNT_EN enables the drop counter.
module poly_result_serializer #(
  parameter int WIDTH       = 32,
  parameter int NUM_LANES   = 8,
  parameter int FRAME_DEPTH = 4,
  localparam int LW = $clog2(NUM_LANES),
  localparam int CW = $clog2(FRAME_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data [NUM_LANES],
  input  logic                    in_valid,
  poly_result_serializer_if.master stream,
  output logic [CW-1:0]           frame_count,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int AW = $clog2(FRAME_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

  logic [WIDTH-1:0] mem [FRAME_DEPTH][NUM_LANES];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    lane;

  logic empty;
  logic full;
  logic xfer;
  logic last_xfer;
  logic wr_en;
  logic drop;
  logic [PW-1:0] diff;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  assign xfer      = !empty && stream.out_ready;
  assign last_xfer = xfer && (lane == LAST);

  // a full FIFO still accepts when the head frame retires this cycle
  assign wr_en = in_valid && (!full || last_xfer);
  assign drop  = in_valid && full && !last_xfer;

  assign diff        = wr_ptr - rd_ptr;
  assign frame_count = CW'(diff);

  assign stream.out_data  = mem[rd_ptr[AW-1:0]][lane];
  assign stream.out_lane  = lane;
  assign stream.out_last  = (lane == LAST);
  assign stream.out_valid = !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        mem[wr_ptr[AW-1:0]][i] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      lane   <= '0;
    end else if (xfer) begin
      if (lane == LAST) begin
        lane   <= '0;
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        lane <= lane + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef POLY_RESULT_SERIALIZER_DROP_COUNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_poly_result_serializer.sv
// Self-checking bench for poly_result_serializer.
// Scoreboard of lane words plus table-driven frame bursts.
module tb_poly_result_serializer;

  localparam int W  = 32;
  localparam int NL = 8;
  localparam int FD = 4;

`ifdef POLY_RESULT_SERIALIZER_DROP_COUNT_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data [NL];
  logic          in_valid;
  logic [2:0]    frame_count;
  logic          overflow;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  poly_result_serializer_if #(.WIDTH(W), .NUM_LANES(NL)) s_if ();

  poly_result_serializer #(
    .WIDTH(W),
    .NUM_LANES(NL),
    .FRAME_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .stream(s_if.master),
    .frame_count(frame_count),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   lane;
  } exp_t;

  typedef struct {
    int       base;
    int       nfr;
    bit [7:0] rdy_pat;
    int       exp_cnt;
  } vec_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // word checker and stall-stability checker at the falling edge
  initial begin
    exp_t e;
    bit   held = 0;
    logic [W-1:0] h_d;
    logic [2:0]   h_l;
    logic         h_last;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          checks++;
          if (s_if.out_valid !== 1'b1 || s_if.out_data !== h_d ||
              s_if.out_lane !== h_l || s_if.out_last !== h_last) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b d=%0h lane=%0d, required v=1 d=%0h lane=%0d",
                     s_if.out_valid, s_if.out_data, s_if.out_lane, h_d, h_l);
          end
        end
        if (s_if.out_valid && s_if.out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got d=%0h lane=%0d, required none",
                     s_if.out_data, s_if.out_lane);
          end else begin
            e = sb.pop_front();
            if (s_if.out_data !== e.d || s_if.out_lane !== e.lane ||
                s_if.out_last !== (e.lane == 3'd7)) begin
              errors++;
              $display("FAIL word: got d=%0h lane=%0d last=%0b, required d=%0h lane=%0d last=%0b",
                       s_if.out_data, s_if.out_lane, s_if.out_last,
                       e.d, e.lane, (e.lane == 3'd7));
            end
          end
        end
        held   = s_if.out_valid && !s_if.out_ready;
        h_d    = s_if.out_data;
        h_l    = s_if.out_lane;
        h_last = s_if.out_last;
      end
    end
  end

  // drives nfr frames back to back; frames with index < npush are expected out
  task automatic send_frames(int base, int nfr, int npush);
    exp_t e;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < NL; i++) in_data[i] = W'(base + f * 16 + i);
      in_valid = 1'b1;
      if (f < npush) begin
        for (int i = 0; i < NL; i++) begin
          e.d = W'(base + f * 16 + i);
          e.lane = 3'(i);
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(string name, bit [7:0] pat);
    int cyc = 0;
    while (sb.size() > 0 && cyc < 400) begin
      s_if.out_ready = pat[cyc % 8];
      @(posedge clk); #1;
      cyc++;
    end
    s_if.out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words left, required 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{base: 1000, nfr: 1, rdy_pat: 8'hFF, exp_cnt: 1};
    vecs[1] = '{base: 2000, nfr: 1, rdy_pat: 8'b1001_1001, exp_cnt: 1};
    vecs[2] = '{base: 3000, nfr: 3, rdy_pat: 8'hAA, exp_cnt: 3};
    vecs[3] = '{base: 4000, nfr: 4, rdy_pat: 8'hFF, exp_cnt: 4};
    vecs[4] = '{base: 5000, nfr: 2, rdy_pat: 8'h5B, exp_cnt: 2};

    in_valid = 1'b0;
    s_if.out_ready = 1'b0;
    for (int i = 0; i < NL; i++) in_data[i] = '0;

    @(negedge clk);
    chk("rst_valid", 32'(s_if.out_valid), 0);
    chk("rst_cnt", 32'(frame_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single frame, ready held high
    s_if.out_ready = 1'b1;
    send_frames(100, 1, 1);
    @(negedge clk);
    chk("single_valid", 32'(s_if.out_valid), 1);
    chk("single_cnt", 32'(frame_count), 1);
    chk("single_lane0", 32'(s_if.out_lane), 0);
    @(posedge clk); #1;
    drain("single", 8'hFF);
    @(negedge clk);
    chk("single_end_valid", 32'(s_if.out_valid), 0);
    chk("single_end_cnt", 32'(frame_count), 0);
    @(posedge clk); #1;

    // bursts drained with assorted ready patterns
    for (int v = 0; v < 5; v++) begin
      s_if.out_ready = 1'b0;
      send_frames(vecs[v].base, vecs[v].nfr, vecs[v].nfr);
      @(negedge clk);
      chk($sformatf("v%0d_cnt", v), 32'(frame_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_valid", v), 32'(s_if.out_valid), 1);
      @(posedge clk); #1;
      drain($sformatf("v%0d", v), vecs[v].rdy_pat);
      @(negedge clk);
      chk($sformatf("v%0d_end_cnt", v), 32'(frame_count), 0);
      chk($sformatf("v%0d_end_valid", v), 32'(s_if.out_valid), 0);
      chk($sformatf("v%0d_ovf", v), 32'(overflow), 0);
      @(posedge clk); #1;
    end

    // full FIFO accepts a frame on the head's final-word cycle
    s_if.out_ready = 1'b0;
    send_frames(6000, 4, 4);
    s_if.out_ready = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
    end
    send_frames(7000, 1, 1);
    s_if.out_ready = 1'b0;
    @(negedge clk);
    chk("simul_cnt", 32'(frame_count), 4);
    chk("simul_ovf", 32'(overflow), 0);
    chk("simul_drop", 32'(drop_count), 0);
    @(posedge clk); #1;
    drain("simul", 8'hFF);

    // fill and drop: fifth frame is lost
    s_if.out_ready = 1'b0;
    send_frames(8000, 5, 4);
    @(negedge clk);
    chk("fill_cnt", 32'(frame_count), 4);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_drop", 32'(drop_count), 32'(DC_EN));
    @(posedge clk); #1;
    drain("fill", 8'hFF);
    @(negedge clk);
    chk("fill_end_cnt", 32'(frame_count), 0);
    chk("fill_ovf_sticky", 32'(overflow), 1);
    @(posedge clk); #1;

    // reset in the middle of a frame
    send_frames(9000, 1, 1);
    s_if.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    s_if.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(s_if.out_valid), 0);
    chk("mid_rst_cnt", 32'(frame_count), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_drop", 32'(drop_count), 0);
    sb.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    s_if.out_ready = 1'b1;
    send_frames(9500, 1, 1);
    @(negedge clk);
    chk("post_rst_lane", 32'(s_if.out_lane), 0);
    chk("post_rst_data", s_if.out_data, 9500);
    @(posedge clk); #1;
    drain("post_rst", 8'hFF);

`ifdef POLY_RESULT_SERIALIZER_DROP_COUNT_EN
    // saturate the drop counter
    s_if.out_ready = 1'b0;
    for (int i = 0; i < NL; i++) in_data[i] = W'(i);
    in_valid = 1'b1;
    repeat (FD + 65540) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_drop", 32'(drop_count), 32'hFFFF);
    chk("sat_cnt", 32'(frame_count), 4);
    @(posedge clk); #1;
    do_reset();
`endif

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
